// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue.sv -- sequential instruction fetch front end with redirect flush.
// Optional build macro: FETCH_PERF_EN (adds the stall/flush performance counters).
//
// Ports (inst_fetch_queue):
//   clk_i, rst_i          clock (rising edge) and asynchronous active-low reset
//   start_i               fetch enable; low stops new requests being launched
//   mem_req_o/addr_o      word fetch request, held stable until mem_gnt_i
//   mem_gnt_i             memory accepted the presented request
//   mem_rvalid_i/rdata_i  in-order response stream
//   inst_valid_o/_o/pc_o  buffered head word and its PC towards decode
//   inst_ready_i          decode consumes the head when valid & ready
//   redirect_i/pc_i       one-cycle redirect: flush and restart fetch at the new PC
//   perf_stall_o/flush_o  performance counters (zero unless FETCH_PERF_EN)

// Generic FIFO: circular buffer with a synchronous flush.
// Latency: a word pushed in cycle N is readable at the head from cycle N+1; no bypass.
// Backpressure: none internally; callers must never push into a full FIFO without popping.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush,
    input  logic                   push_vld,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // The extra pointer bit separates full from empty; DEPTH is a power of two so
    // the low bits wrap naturally.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_vld) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only observed while count is non-zero.
    always_ff @(posedge clk_i) begin
        if (push_vld && !flush) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

    assign head_dat = mem[rd_ptr[AW-1:0]];
    assign count    = wr_ptr - rd_ptr;
endmodule

// Fetch queue: issues sequential word fetches and buffers {pc, word} for decode.
// Latency: request presented the cycle after credit frees; response visible at head one cycle after rvalid.
// Backpressure: decode stalls fill the FIFO; credit (outstanding + buffered < DEPTH) then stops fetching.
module inst_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    input  logic        inst_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] perf_stall_o,
    output logic [31:0] perf_flush_o
);
    localparam int              AW        = $clog2(DEPTH);
    localparam int              CW        = AW + 1;
    localparam logic [CW-1:0]   MAX_OUT_C = CW'(MAX_OUT);
    localparam logic [CW:0]     DEPTH_C   = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic          req_q;
    logic [CW-1:0] out_cnt;
    logic [CW-1:0] drop_cnt;

    logic [CW-1:0] out_nxt;
    logic [CW-1:0] drop_nxt;
    logic [CW-1:0] fifo_cnt_nxt;
    logic [CW:0]   credit_sum;
    logic          req_nxt;

    logic          grant;
    logic          rsp;
    logic          rsp_drop;
    logic          push;
    logic          pop;

    logic [CW-1:0] fifo_cnt;
    logic [CW-1:0] tag_cnt;
    logic [31:0]   tag_pc;
    logic [63:0]   head_dat;
    logic          unused_bits;

    // Redirect withdraws any unaccepted request combinationally, so a grant in
    // the redirect cycle can never be taken.
    assign mem_req_o  = req_q & ~redirect_i;
    assign mem_addr_o = fetch_pc;
    assign grant      = mem_req_o & mem_gnt_i;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp      = mem_rvalid_i & (out_cnt != '0);
    assign rsp_drop = rsp & (drop_cnt != '0);
    assign push     = rsp & (drop_cnt == '0) & ~redirect_i;

    assign inst_valid_o = (fifo_cnt != '0);
    assign pop          = inst_valid_o & inst_ready_i & ~redirect_i;

    always_comb begin
        out_nxt      = out_cnt + CW'(grant) - CW'(rsp);
        drop_nxt     = drop_cnt - CW'(rsp_drop);
        fifo_cnt_nxt = fifo_cnt + CW'(push) - CW'(pop);
        if (redirect_i) begin
            // Every response still owed after this cycle belongs to the old path.
            drop_nxt     = out_nxt;
            fifo_cnt_nxt = '0;
        end

        credit_sum = {1'b0, out_nxt} + {1'b0, fifo_cnt_nxt};

        // Credit is evaluated on next-cycle occupancy. The presented request is
        // not yet counted as outstanding, but outstanding + buffered cannot grow
        // while it waits for a grant, so the FIFO cannot overflow.
        if (!redirect_i && req_q && !mem_gnt_i) begin
            req_nxt = 1'b1;
        end else begin
            req_nxt = start_i && (out_nxt < MAX_OUT_C) && (credit_sum < DEPTH_C)
                      && (drop_nxt == '0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_pc <= RESET_PC;
            req_q    <= 1'b0;
            out_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            req_q    <= req_nxt;
            out_cnt  <= out_nxt;
            drop_cnt <= drop_nxt;
            if (redirect_i) begin
                fetch_pc <= {redirect_pc_i[31:2], 2'b00};
            end else if (grant) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
        end
    end

    // PCs of granted requests, consumed in order as their responses are kept.
    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_tag_q (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .flush    (redirect_i),
        .push_vld (grant),
        .push_dat (fetch_pc),
        .pop      (push),
        .head_dat (tag_pc),
        .count    (tag_cnt)
    );

    fetch_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_inst_q (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .flush    (redirect_i),
        .push_vld (push),
        .push_dat ({tag_pc, mem_rdata_i}),
        .pop      (pop),
        .head_dat (head_dat),
        .count    (fifo_cnt)
    );

    // Masked so the head reads zero whenever nothing valid is buffered.
    assign inst_o    = inst_valid_o ? head_dat[31:0]  : '0;
    assign inst_pc_o = inst_valid_o ? head_dat[63:32] : '0;

    // Tag occupancy always tracks outstanding kept fetches; low redirect bits are forced to zero.
    assign unused_bits = ^{tag_cnt, redirect_pc_i[1:0]};

`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    logic [CW:0] flush_inc;
    logic        stall_evt;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    assign stall_evt = inst_ready_i & ~inst_valid_o & start_i;

    // Discards are counted where they happen: buffered entries plus any response
    // landing in the redirect cycle, then each stale response as it drains.
    always_comb begin
        flush_inc = {{CW{1'b0}}, rsp_drop};
        if (redirect_i) begin
            flush_inc = {1'b0, fifo_cnt} + {{CW{1'b0}}, rsp};
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            stall_cnt <= sat_add(stall_cnt, {31'b0, stall_evt});
            flush_cnt <= sat_add(flush_cnt, 32'(flush_inc));
        end
    end

    assign perf_stall_o = stall_cnt;
    assign perf_flush_o = flush_cnt;
`else
    assign perf_stall_o = '0;
    assign perf_flush_o = '0;
`endif
endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Instruction fetch front end placed directly upstream of the single-cycle core.
- Issues sequential word fetches to a variable-latency instruction memory over a req/gnt + rvalid interface, and buffers returned words with their PCs in a small FIFO.
- Presents the buffered words to decode through a valid/ready handshake.
- Supports a redirect (branch/jump) that flushes buffered and in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000: fetch PC loaded at reset.
- DEPTH, 4: FIFO entries. Power of two, >= 2.
- MAX_OUT, 2: maximum accepted-but-unreturned memory requests. Range 1..DEPTH.

Ports:
- clk_i  input  1  clock; all state on rising edge.
- rst_i  input  1  reset, asynchronous, active-low. Asserted low clears all state immediately.
- start_i  input  1  fetch enable; when low, no new request is launched.
- mem_req_o  output  1  fetch request valid.
- mem_addr_o  output  32  fetch word address; bits [1:0] always 0.
- mem_gnt_i  input  1  memory accepts the request this cycle.
- mem_rvalid_i  input  1  response valid; responses return in request order.
- mem_rdata_i  input  32  response instruction word.
- inst_valid_o  output  1  FIFO head valid.
- inst_o  output  32  head instruction.
- inst_pc_o  output  32  head PC.
- inst_ready_i  input  1  decode consumes the head when both valid and ready are high.
- redirect_i  input  1  one-cycle redirect pulse.
- redirect_pc_i  input  32  new fetch PC.
- perf_stall_o  output  32  see Optional Feature.
- perf_flush_o  output  32  see Optional Feature.

Behaviour:
- Reset values:
  - fetch_pc = RESET_PC.
  - FIFO empty; outstanding = 0; drop = 0.
  - mem_req_o = 0, mem_addr_o = RESET_PC, inst_valid_o = 0, inst_o = 0, inst_pc_o = 0, perf outputs = 0.
- Credit rule: launch a request only when start_i=1 and all of the following hold:
  - outstanding < MAX_OUT;
  - outstanding + fifo_count < DEPTH;
  - drop == 0.
  - This rule guarantees the FIFO never overflows.
- Once mem_req_o rises, it and mem_addr_o stay stable until mem_gnt_i=1, regardless of start_i. The only exception is redirect.
- Grant (mem_req_o & mem_gnt_i):
  - outstanding += 1;
  - fetch_pc += 4, wrapping modulo 2^32;
  - the PC of the granted request is pushed into an internal PC tag queue.
- A new request may be presented in the cycle after a grant, giving back-to-back throughput of 1 word/cycle when MAX_OUT >= 2.
- Response (mem_rvalid_i):
  - outstanding -= 1.
  - If drop > 0: drop -= 1 and the data is discarded.
  - Otherwise: {tag PC, rdata} is written into the FIFO.
  - mem_rvalid_i when outstanding = 0 is a protocol error; ignore it.
- FIFO:
  - Registered output. A word written in cycle N is visible at the head no earlier than cycle N+1; there is no bypass.
  - Simultaneous push and pop is allowed at any occupancy, including full.
  - Pointers wrap modulo DEPTH.
- Redirect (redirect_i=1), all in the same cycle:
  - FIFO and tag queue flushed; inst_valid_o = 0 next cycle.
  - drop = outstanding minus responses arriving this cycle.
  - fetch_pc = {redirect_pc_i[31:2], 2'b00}.
  - mem_req_o forced low this cycle, withdrawing any unaccepted request; a grant in this cycle is ignored.
  - Fetch resumes the next cycle once drop == 0 and credit allows.
  - Redirect takes priority over pop, push and grant in the same cycle.
  - A redirect during drop > 0 recomputes drop the same way; the total equals all responses still owed.
- Reset asserted mid-transaction abandons everything. The memory side must also be reset.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined:
  - perf_stall_o counts cycles with inst_ready_i=1 & inst_valid_o=0 & start_i=1.
  - perf_flush_o counts valid FIFO entries discarded plus responses dropped due to redirect.
  - Both counters are 32-bit, saturating at 32'hFFFF_FFFF, and reset to 0.
- Undefined: both outputs tied to 0 and the counter logic is omitted.

Test Plan:
- Streaming: fixed 1-cycle memory latency, gnt always 1, ready always 1, start_i=1 after reset → inst_pc_o = 0, 4, 8, 12 on consecutive cycles, with rdata matching the address pattern.
- Backpressure: ready=0 for 20 cycles → exactly DEPTH=4 entries are buffered, mem_req_o drops to 0 with no overflow; releasing ready drains PCs 0, 4, 8, 12 in order.
- Grant stall: gnt=0 for 5 cycles with start_i toggled low in between → mem_req_o and mem_addr_o stay constant at 0 until granted.
- Redirect with 2 outstanding, 3-cycle latency: redirect to 0x0000_0102 → both stale responses are dropped, the next fetch address is 0x0000_0100, and no stale PC appears at inst_pc_o.
- Async reset low mid-stream with the clock stopped → outputs reach reset values immediately; after release, the first fetch is at RESET_PC.
- FETCH_PERF_EN defined: force 3 empty-ready cycles, then redirect with 2 entries buffered and 1 outstanding → perf_stall_o = 3, perf_flush_o = 3.
